// File: rtl/key_sched_gen.sv
// Iterative AES-128 key schedule: one round key per clock from the initial key words.
// Optional round-key store enabled by defining KEY_SCHED_STORE_EN.

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Forward S-box, entry 0x00 in the most-significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX_TABLE[{~i_byte, 3'b000} +: 8];
endmodule

module key_sched_gen #(
    parameter int KEY_LENGTH = 128,
    parameter int NR         = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [KEY_LENGTH-1:0] i_key,
    output logic [KEY_LENGTH-1:0] o_round_key,
    output logic [3:0]            o_round_idx,
    output logic                  o_rk_valid,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic [3:0]            i_rd_idx,
    output logic [KEY_LENGTH-1:0] o_rd_key
);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic [KEY_LENGTH-1:0]   r_words;
    logic [KEY_LENGTH-1:0]   w_words_next;
    logic                    r_busy;
    logic                    w_busy_next;
    logic                    r_done;
    logic                    w_done_next;

    logic [7:0]              w_rcon;
    logic [31:0]             w_rot;
    logic [31:0]             w_sub;
    logic [31:0]             w_t;
    logic [31:0]             w_n0;
    logic [31:0]             w_n1;
    logic [31:0]             w_n2;
    logic [31:0]             w_n3;

    // Rcon for the round being derived (counter r produces round r+1).
    always_comb begin
        w_rcon = 8'h00;
        case (r_cnt)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign w_rot = {r_words[119:96], r_words[127:120]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {w_rcon, 24'h000000};
    assign w_n0 = r_words[31:0]   ^ w_t;
    assign w_n1 = r_words[63:32]  ^ w_n0;
    assign w_n2 = r_words[95:64]  ^ w_n1;
    assign w_n3 = r_words[127:96] ^ w_n2;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_words_next = r_words;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = 4'd0;
                    w_words_next = i_key;
                    w_busy_next  = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_ROUND) begin
                    // Round key and index stay on the outputs; only valid drops.
                    w_state_next = ST_IDLE;
                    w_busy_next  = 1'b0;
                end else begin
                    w_cnt_next   = r_cnt + 4'd1;
                    w_words_next = {w_n3, w_n2, w_n1, w_n0};
                    w_done_next  = ((r_cnt + 4'd1) == LAST_ROUND);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_words <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_words <= w_words_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    assign o_round_key = r_words;
    assign o_round_idx = r_cnt;
    assign o_rk_valid  = r_busy;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

`ifdef KEY_SCHED_STORE_EN
    logic [KEY_LENGTH-1:0] r_store [0:NR];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i <= NR; i++) begin
                r_store[i] <= '0;
            end
        end else if (r_busy) begin
            r_store[r_cnt] <= r_words;
        end
    end

    assign o_rd_key = (i_rd_idx <= LAST_ROUND) ? r_store[i_rd_idx] : '0;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^i_rd_idx;
    assign o_rd_key    = '0;
`endif

endmodule
